// File: rtl/shift_reg_rx.sv
// -----------------------------------------------------------------------------
// shift_reg_rx
//   Serial-in, parallel-out receive shift register for the SSP receive path.
//   Each enabled clock shifts one serial bit into a WIDTH-bit register. A bit
//   counter flags every completed frame with a one-cycle pulse, so downstream
//   control can capture q without tracking bit position itself.
//
//   Shift direction is selected at build time by macro SHIFT_REG_RX_LSB_FIRST_EN:
//     undefined (default) : MSB-first, q <= {q[WIDTH-2:0], sig_i}
//     defined             : LSB-first, q <= {sig_i, q[WIDTH-1:1]}
//   Counter, frame pulse and reset behave identically in both builds.
//
// Parameters
//   WIDTH         frame length and width of q (2..32), default 8
//
// Ports
//   clk_i         system clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset, priority over en
//   sig_i         serial receive data bit, sampled when en=1
//   en            shift enable; register and counter hold when low
//   q             registered parallel register contents
//   bit_cnt_o     registered count of bits received in current frame
//   frame_done_o  registered one-cycle pulse after the last bit of a frame
// -----------------------------------------------------------------------------
module shift_reg_rx #(
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sig_i,
  input  logic                     en,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(WIDTH)-1:0] bit_cnt_o,
  output logic                     frame_done_o
);

  localparam int            CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_frame_done;

  logic [WIDTH-1:0] w_q_shifted;
  logic             w_last_bit;

  // Next register contents with the new bit inserted at the build's entry end.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             din);
`ifdef SHIFT_REG_RX_LSB_FIRST_EN
    shift_in = {din, cur[WIDTH-1:1]};
`else
    shift_in = {cur[WIDTH-2:0], din};
`endif
  endfunction

  assign w_q_shifted = shift_in(r_q, sig_i);
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);

  // Register stage: shift data, count bits, raise the frame pulse on wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q          <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else if (en) begin
      r_q <= w_q_shifted;
      if (w_last_bit) begin
        r_bit_cnt    <= '0;
        r_frame_done <= 1'b1;
      end else begin
        r_bit_cnt    <= r_bit_cnt + 1'b1;
        r_frame_done <= 1'b0;
      end
    end else begin
      // Hold data and count; the pulse only ever lasts one cycle.
      r_frame_done <= 1'b0;
    end
  end

  assign q            = r_q;
  assign bit_cnt_o    = r_bit_cnt;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_shift_reg_rx.sv
module tb_shift_reg_rx;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         sig_i;
  logic         en;
  logic [W-1:0] q;
  logic [2:0]   bit_cnt_o;
  logic         frame_done_o;

  shift_reg_rx #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sig_i        (sig_i),
    .en           (en),
    .q            (q),
    .bit_cnt_o    (bit_cnt_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state and frame scoreboard.
  logic [W-1:0] m_q    = '0;
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] exp_q[$];

  // Drive one clock of stimulus, advance the model, settle 1 time unit past the edge.
  task automatic cycle(input logic r, input logic s, input logic e);
    rst_i = r;
    sig_i = s;
    en    = e;
    @(posedge clk_i);
    if (r) begin
      m_q    = '0;
      m_cnt  = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else if (e) begin
`ifdef SHIFT_REG_RX_LSB_FIRST_EN
      m_q = {s, m_q[W-1:1]};
`else
      m_q = {m_q[W-2:0], s};
`endif
      if (m_cnt == W - 1) begin
        m_cnt  = 0;
        m_done = 1'b1;
        exp_q.push_back(m_q);
      end else begin
        m_cnt  = m_cnt + 1;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      n_asrt++;
      if (q !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_q cyc=%0d got=%h exp=00", i, q);
      end
      n_asrt++;
      if (bit_cnt_o !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", i, bit_cnt_o);
      end
      n_asrt++;
      if (frame_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_done cyc=%0d got=%b exp=0", i, frame_done_o);
      end
    end
  endtask

  task automatic test_partial_shift();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      n_asrt++;
      if (frame_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_done cyc=%0d got=%b exp=0", i, frame_done_o);
      end
    end
    n_asrt++;
`ifdef SHIFT_REG_RX_LSB_FIRST_EN
    if (q !== 8'hF8) begin
      n_fail++;
      $display("FAIL partial_q got=%h exp=f8", q);
    end
`else
    if (q !== 8'h1F) begin
      n_fail++;
      $display("FAIL partial_q got=%h exp=1f", q);
    end
`endif
    n_asrt++;
    if (bit_cnt_o !== 3'd5) begin
      n_fail++;
      $display("FAIL partial_cnt got=%0d exp=5", bit_cnt_o);
    end
  endtask

  task automatic test_hold_shift_zeros();
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      n_asrt++;
      if (q !== m_q || bit_cnt_o !== 3'd5) begin
        n_fail++;
        $display("FAIL hold cyc=%0d got q=%h cnt=%0d exp q=%h cnt=5", i, q, bit_cnt_o, m_q);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      n_asrt++;
      if (frame_done_o !== (i == 2)) begin
        n_fail++;
        $display("FAIL zeros_done cyc=%0d got=%b exp=%b", i, frame_done_o, (i == 2));
      end
    end
    n_asrt++;
`ifdef SHIFT_REG_RX_LSB_FIRST_EN
    if (q !== 8'h1F) begin
      n_fail++;
      $display("FAIL zeros_q got=%h exp=1f", q);
    end
`else
    if (q !== 8'hF8) begin
      n_fail++;
      $display("FAIL zeros_q got=%h exp=f8", q);
    end
`endif
    n_asrt++;
    if (bit_cnt_o !== 3'd0) begin
      n_fail++;
      $display("FAIL zeros_cnt got=%0d exp=0", bit_cnt_o);
    end
    n_asrt++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL zeros_sb got=empty exp=one frame");
    end else begin
      e = exp_q.pop_front();
      if (q !== e) begin
        n_fail++;
        $display("FAIL zeros_sb got=%h exp=%h", q, e);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    n_asrt++;
    if (frame_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zeros_pulse_width got=%b exp=0", frame_done_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic [W-1:0] e;
    int pulses;
    int pulse_cyc[2];
    stream = 16'hA53C;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, stream[15 - i], 1'b1);
      if (frame_done_o === 1'b1) begin
        if (pulses < 2) pulse_cyc[pulses] = i;
        pulses++;
        n_asrt++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_sb cyc=%0d got=%h exp=none", i, q);
        end else begin
          e = exp_q.pop_front();
          if (q !== e) begin
            n_fail++;
            $display("FAIL b2b_sb cyc=%0d got=%h exp=%h", i, q, e);
          end
        end
`ifndef SHIFT_REG_RX_LSB_FIRST_EN
        n_asrt++;
        if (q !== (pulses == 1 ? 8'hA5 : 8'h3C)) begin
          n_fail++;
          $display("FAIL b2b_q cyc=%0d got=%h exp=%h", i, q, (pulses == 1 ? 8'hA5 : 8'h3C));
        end
`endif
      end
    end
    n_asrt++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL b2b_pulses got=%0d exp=2", pulses);
    end else begin
      n_asrt++;
      if (pulse_cyc[0] != 7 || pulse_cyc[1] != 15) begin
        n_fail++;
        $display("FAIL b2b_spacing got=%0d,%0d exp=7,15", pulse_cyc[0], pulse_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] frame;
    frame = 8'h81;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    n_asrt++;
    if (q !== 8'h00 || bit_cnt_o !== 3'd0 || frame_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got q=%h cnt=%0d done=%b exp q=00 cnt=0 done=0", q, bit_cnt_o, frame_done_o);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, frame[7 - i], 1'b1);
      n_asrt++;
      if (frame_done_o !== (i == 7)) begin
        n_fail++;
        $display("FAIL mid_done bit=%0d got=%b exp=%b", i, frame_done_o, (i == 7));
      end
    end
    // 0x81 reads the same in either shift direction.
    n_asrt++;
    if (q !== 8'h81) begin
      n_fail++;
      $display("FAIL mid_q got=%h exp=81", q);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits;
    bits = 8'b1010_0101;  // sent in order bits[7] .. bits[0] = 1,0,1,0,0,1,0,1
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, bits[7 - i], 1'b1);
      n_asrt++;
      if (frame_done_o !== (i == 7)) begin
        n_fail++;
        $display("FAIL order_done bit=%0d got=%b exp=%b", i, frame_done_o, (i == 7));
      end
    end
    // This bit sequence is a palindrome, so both builds must show 0xA5.
    n_asrt++;
    if (q !== 8'hA5) begin
      n_fail++;
      $display("FAIL order_q got=%h exp=a5", q);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      n_asrt++;
      if (q !== m_q || bit_cnt_o !== 3'(m_cnt) || frame_done_o !== m_done) begin
        n_fail++;
        $display("FAIL rand cyc=%0d got q=%h cnt=%0d done=%b exp q=%h cnt=%0d done=%b",
                 i, q, bit_cnt_o, frame_done_o, m_q, m_cnt, m_done);
      end
      if (frame_done_o === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_asrt++;
        if (q !== e) begin
          n_fail++;
          $display("FAIL rand_sb cyc=%0d got=%h exp=%h", i, q, e);
        end
      end
    end
    n_asrt++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_sb_left got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    rst_i = 1'b1;
    sig_i = 1'b0;
    en    = 1'b0;
    test_reset();
    test_partial_shift();
    test_hold_shift_zeros();
    test_back_to_back();
    test_reset_mid_frame();
    test_lsb_first();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
